oled_text_sequencer: RTL and testbench
======================================

Name: oled_text_sequencer

Overview:
- Holds a 4x16 character frame buffer and keeps the OLED panel in sync with it.
- Sits between application logic and the OLED driver block (its showchar/clear/ready request interface).
- Host writes cells at any rate. The block tracks dirty cells and sequences one showchar request per dirty cell, plus full-screen clears, through the driver's single-request handshake.

Parameters:
- ROWS, 4, character rows; row index width 2.
- COLS, 16, character columns; column index width 4.
- BLANK_CHAR, 8'h20, cell value after reset or clear.
- WDOG_CYCLES, 2000000, driver-response timeout in clk cycles. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- wr_en  in  1  write one cell this cycle
- wr_row  in  2  cell row
- wr_col  in  4  cell column
- wr_char  in  8  character code
- clr_req  in  1  pulse: request full clear
- busy  out  1  high while any dirty cell, pending clear or outstanding request exists
- drv_ready  in  1  driver idle and accepting a request
- drv_showchar  out  1  one-cycle request: draw one char
- drv_clear  out  1  one-cycle request: clear screen
- drv_char_row  out  2  row for showchar
- drv_char_col  out  4  column for showchar
- drv_charval  out  8  char for showchar
- err  out  1  sticky timeout flag; constant 0 without the feature

Behaviour:
- Reset:
  - All 64 cells = BLANK_CHAR; all dirty bits 0; clear_pend = 0; scan pointer = 0; state IDLE.
  - All drv_* outputs 0; busy = 0; err = 0.
- Cell index: row*COLS + col, range 0..63.
- Write:
  - wr_en stores wr_char into the cell and sets its dirty bit on the next edge.
  - Writes are accepted in every state; there is no back-pressure.
- Clear request: clr_req sets clear_pend. Repeated pulses while pending coalesce.
- States:
  - IDLE: if clear_pend, go to C_ISSUE. Else if the cell at the scan pointer is dirty, go to ISSUE. Else advance the scan pointer by 1, wrapping 63->0.
  - ISSUE: wait for drv_ready=1. In that cycle:
    - assert drv_showchar for exactly one cycle, with row/col/char taken from the current cell contents;
    - clear that cell's dirty bit;
    - go to WAIT_ACK.
  - WAIT_ACK: wait for drv_ready=0, then go to WAIT_DONE.
  - WAIT_DONE: wait for drv_ready=1; advance the scan pointer; go to IDLE.
  - C_ISSUE: wait for drv_ready=1, then:
    - pulse drv_clear for one cycle;
    - set all cells to BLANK_CHAR and all dirty bits to 0;
    - clear clear_pend;
    - go to C_WAIT_ACK.
  - C_WAIT_ACK and C_WAIT_DONE: same as WAIT_ACK and WAIT_DONE, then go to IDLE.
- drv_char_row, drv_char_col and drv_charval are registered and held stable from the ISSUE cycle until the next issue.
- Priority: a pending clear beats dirty cells, but only at IDLE. An in-flight showchar completes first.
- Simultaneous events:
  - wr_en to the cell being issued in the ISSUE cycle: the new value is stored and dirty stays 1, so the cell is redrawn later.
  - wr_en in the C_ISSUE cycle: the write wins for that cell (new char, dirty=1); all other cells blank.
  - clr_req in the same cycle that clear_pend is cleared: clear_pend stays 1, so a second clear follows.
- Scan latency: worst case 64 cycles from IDLE to finding a dirty cell.
- No dirty cell is lost: each write leads to at least one showchar carrying that cell's latest value, unless a later clear supersedes it.
- busy is combinational: (state != IDLE) | clear_pend | (|dirty).
- drv_showchar and drv_clear are never both high.
- Reset mid-operation returns to the reset state immediately. The driver's own handshake recovers on its next ready.

Optional Feature:
- Macro: OLED_SEQ_WATCHDOG_EN.
- With it:
  - A counter runs in ISSUE, WAIT_ACK, WAIT_DONE and the C_* states, and resets on every state change.
  - Reaching WDOG_CYCLES sets err (sticky until rst) and forces IDLE.
  - A timed-out cell's dirty bit is set again.
  - A timed-out clear leaves clear_pend set.
- Without it: no counter; err tied to 0; the waits are unbounded.

Decomposition:
- Package oled_seq_pkg holds:
  - state enum seq_state_t;
  - ROW_W=2, COL_W=4, CELLS=64;
  - BLANK_CHAR default;
  - cell_idx function (row, col -> 6-bit index).
- One natural sub-module: oled_seq_cellbuf. It holds the 64x8 storage plus dirty bits, with a write port, a clear-all, an indexed read and a dirty-clear port with write-wins priority.

Test Plan:
- Reset, driver ready=1, no writes -> busy=0, no drv_showchar or drv_clear over 200 cycles.
- Write (row 1, col 3, 8'h41); driver model acks after 10 cycles -> exactly one drv_showchar with row=1, col=3, char=8'h41; busy falls after drv_ready returns.
- Write 8'h41 then 8'h42 to (0,0) during its WAIT_ACK -> two showchars, with values 8'h41 then 8'h42.
- Dirty cells 5 and 60, then clr_req while cell 5 is in flight -> cell 5 showchar completes; then one drv_clear; no showchar for cell 60.
- Write in the same cycle as the ISSUE of that cell (col 7, 8'h5A) -> a later second showchar carries 8'h5A.
- OLED_SEQ_WATCHDOG_EN with WDOG_CYCLES=50, driver holds ready=0 after accept -> err=1 at cycle 50; state returns to IDLE; cell reissued once ready recovers.

Source files
------------

// File: rtl/oled_seq_pkg.sv
// oled_seq_pkg
// Shared types and constants for the OLED text sequencer: frame geometry,
// default blank character, FSM state encoding and the row/col -> cell index
// mapping used by both the top level and the cell buffer.
package oled_seq_pkg;

  localparam int ROW_W = 2;
  localparam int COL_W = 4;
  localparam int IDX_W = ROW_W + COL_W;
  localparam int CELLS = 64;

  localparam logic [7:0] BLANK_CHAR_DEF = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_C_ISSUE,
    S_C_WAIT_ACK,
    S_C_WAIT_DONE
  } seq_state_t;

  // Cell index is row*16 + col, which is just the concatenation.
  function automatic logic [IDX_W-1:0] cell_idx(input logic [ROW_W-1:0] row,
                                                input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/oled_seq_cellbuf.sv
// oled_seq_cellbuf
// 64x8 character storage with one dirty bit per cell.
// Ports:
//   clk, rst            clock, async active-high reset (all cells blank, clean)
//   wr_en/wr_idx/wr_char host write; stores char and marks the cell dirty
//   clr_all             blank every cell and clear every dirty bit
//   rd_idx -> rd_char, rd_dirty   combinational indexed read
//   dclr_en/dclr_idx    clear one dirty bit (cell handed to the driver)
//   dset_en/dset_idx    set one dirty bit (request that never completed)
//   dirty_any           OR of all dirty bits
// A host write in the same cycle as clr_all or a dirty-clear wins for its cell.
module oled_seq_cellbuf
  import oled_seq_pkg::*;
#(
  parameter logic [7:0] BLANK_CHAR = BLANK_CHAR_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_char,
  input  logic             clr_all,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_char,
  output logic             rd_dirty,
  input  logic             dclr_en,
  input  logic [IDX_W-1:0] dclr_idx,
  input  logic             dset_en,
  input  logic [IDX_W-1:0] dset_idx,
  output logic             dirty_any
);

  logic [7:0]       mem [CELLS];
  logic [CELLS-1:0] dirty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= BLANK_CHAR;
      dirty <= '0;
    end else begin
      if (clr_all) begin
        for (int i = 0; i < CELLS; i++) mem[i] <= BLANK_CHAR;
        dirty <= '0;
      end else if (dclr_en) begin
        dirty[dclr_idx] <= 1'b0;
      end
      if (dset_en) dirty[dset_idx] <= 1'b1;
      // Last assignment wins: a write always leaves its cell dirty.
      if (wr_en) begin
        mem[wr_idx]   <= wr_char;
        dirty[wr_idx] <= 1'b1;
      end
    end
  end

  assign rd_char   = mem[rd_idx];
  assign rd_dirty  = dirty[rd_idx];
  assign dirty_any = |dirty;

endmodule

// File: rtl/oled_text_sequencer.sv
// oled_text_sequencer
// Keeps an OLED panel in sync with a 4x16 character frame buffer. The host
// writes cells freely; dirty cells are found by a circular scan and sent one
// at a time as showchar requests, and full-screen clears are sent as clear
// requests, all through the driver's single-request ready handshake.
// Ports:
//   clk, rst                        clock, async active-high reset
//   wr_en, wr_row, wr_col, wr_char  host cell write
//   clr_req                         pulse: request a full clear
//   busy                            work pending or request outstanding
//   drv_ready                       driver idle / accepting
//   drv_showchar, drv_clear         one-cycle registered requests
//   drv_char_row/col, drv_charval   request payload, held until next issue
//   err                             sticky driver-timeout flag
// Build option: define OLED_SEQ_WATCHDOG_EN to add a driver-response
// watchdog of WDOG_CYCLES cycles; otherwise err is tied low and waits are
// unbounded.
//
// state         | meaning
// --------------+---------------------------------------------------------
// S_IDLE        | scanning: clear pending -> clear, dirty cell -> issue
// S_ISSUE       | waiting for drv_ready to hand over the scanned cell
// S_WAIT_ACK    | showchar sent, waiting for driver to drop ready
// S_WAIT_DONE   | driver busy, waiting for ready; then advance scan
// S_C_ISSUE     | waiting for drv_ready to send clear
// S_C_WAIT_ACK  | clear sent, waiting for driver to drop ready
// S_C_WAIT_DONE | driver clearing, waiting for ready
module oled_text_sequencer
  import oled_seq_pkg::*;
#(
  parameter int         ROWS        = 4,
  parameter int         COLS        = 16,
  parameter logic [7:0] BLANK_CHAR  = BLANK_CHAR_DEF,
  parameter int         WDOG_CYCLES = 2000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COL_W-1:0] wr_col,
  input  logic [7:0]       wr_char,
  input  logic             clr_req,
  output logic             busy,
  input  logic             drv_ready,
  output logic             drv_showchar,
  output logic             drv_clear,
  output logic [ROW_W-1:0] drv_char_row,
  output logic [COL_W-1:0] drv_char_col,
  output logic [7:0]       drv_charval,
  output logic             err
);

  if (ROWS * COLS != CELLS || WDOG_CYCLES < 2) begin : g_bad_params
    $error("oled_text_sequencer: need ROWS*COLS == %0d and WDOG_CYCLES >= 2", CELLS);
  end

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] scan_q, scan_d;
  logic             clear_pend_q;
  logic             issue_cell, issue_clear;
  logic [7:0]       rd_char;
  logic             rd_dirty, dirty_any;
  logic             wdog_expired, requeue_cell, requeue_clear;

  oled_seq_cellbuf #(.BLANK_CHAR(BLANK_CHAR)) u_cellbuf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_idx    (cell_idx(wr_row, wr_col)),
    .wr_char   (wr_char),
    .clr_all   (issue_clear),
    .rd_idx    (scan_q),
    .rd_char   (rd_char),
    .rd_dirty  (rd_dirty),
    .dclr_en   (issue_cell),
    .dclr_idx  (scan_q),
    .dset_en   (requeue_cell),
    .dset_idx  (scan_q),
    .dirty_any (dirty_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      scan_q  <= '0;
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    scan_d      = scan_q;
    issue_cell  = 1'b0;
    issue_clear = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (clear_pend_q)  state_d = S_C_ISSUE;
        else if (rd_dirty) state_d = S_ISSUE;
        else               scan_d  = scan_q + 1'b1;
      end
      S_ISSUE: begin
        if (drv_ready) begin
          issue_cell = 1'b1;
          state_d    = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (!drv_ready) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (drv_ready) begin
          scan_d  = scan_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      S_C_ISSUE: begin
        if (drv_ready) begin
          issue_clear = 1'b1;
          state_d     = S_C_WAIT_ACK;
        end
      end
      S_C_WAIT_ACK: begin
        if (!drv_ready) state_d = S_C_WAIT_DONE;
      end
      S_C_WAIT_DONE: begin
        if (drv_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A timeout abandons the request; the scan pointer stays put so the
    // same cell (or the clear) is retried first.
    if (wdog_expired) begin
      state_d     = S_IDLE;
      scan_d      = scan_q;
      issue_cell  = 1'b0;
      issue_clear = 1'b0;
    end
  end

  // A clr_req coinciding with the clear being issued keeps the flag set so a
  // second clear follows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            clear_pend_q <= 1'b0;
    else if (clr_req || requeue_clear)  clear_pend_q <= 1'b1;
    else if (issue_clear)               clear_pend_q <= 1'b0;
  end

  // Requests are registered so the pulse and its payload appear together,
  // one cycle after the handshake decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drv_showchar <= 1'b0;
      drv_clear    <= 1'b0;
      drv_char_row <= '0;
      drv_char_col <= '0;
      drv_charval  <= '0;
    end else begin
      drv_showchar <= issue_cell;
      drv_clear    <= issue_clear;
      if (issue_cell) begin
        drv_char_row <= scan_q[IDX_W-1:COL_W];
        drv_char_col <= scan_q[COL_W-1:0];
        drv_charval  <= rd_char;
      end
    end
  end

  assign busy = (state_q != S_IDLE) | clear_pend_q | dirty_any;

`ifdef OLED_SEQ_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES);

  logic [WDOG_W-1:0] wdog_q;
  logic              err_q;

  // Expires on the WDOG_CYCLES-th consecutive cycle spent in one state.
  assign wdog_expired  = (state_q != S_IDLE) && (wdog_q == WDOG_W'(WDOG_CYCLES - 1));
  assign requeue_cell  = wdog_expired &&
                         (state_q inside {S_ISSUE, S_WAIT_ACK, S_WAIT_DONE});
  assign requeue_clear = wdog_expired &&
                         (state_q inside {S_C_ISSUE, S_C_WAIT_ACK, S_C_WAIT_DONE});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE || state_d != state_q) wdog_q <= '0;
      else                                         wdog_q <= wdog_q + 1'b1;
      if (wdog_expired) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign wdog_expired  = 1'b0;
  assign requeue_cell  = 1'b0;
  assign requeue_clear = 1'b0;
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_oled_text_sequencer.sv
// tb_oled_text_sequencer
// Directed bench with a driver model and a transaction-level reference:
// every host write is queued per cell; each showchar must carry a value the
// cell has held since it was last drawn, a clear drops all writes older than
// its issue cycle, and busy must be high while the reference has work left.
module tb_oled_text_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_row;
  logic [3:0] wr_col;
  logic [7:0] wr_char;
  logic       clr_req;
  logic       busy;
  logic       drv_ready;
  logic       drv_showchar, drv_clear;
  logic [1:0] drv_char_row;
  logic [3:0] drv_char_col;
  logic [7:0] drv_charval;
  logic       err;

  always #5 clk = ~clk;

  oled_text_sequencer #(.WDOG_CYCLES(50)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_row       (wr_row),
    .wr_col       (wr_col),
    .wr_char      (wr_char),
    .clr_req      (clr_req),
    .busy         (busy),
    .drv_ready    (drv_ready),
    .drv_showchar (drv_showchar),
    .drv_clear    (drv_clear),
    .drv_char_row (drv_char_row),
    .drv_char_col (drv_char_col),
    .drv_charval  (drv_charval),
    .err          (err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver model ----------------
  int   drv_cnt = 0;
  int   ack_len = 10;
  logic hold    = 1'b0;
  assign drv_ready = !hold && (drv_cnt == 0);

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst)                            drv_cnt = 0;
      else if (drv_showchar || drv_clear) drv_cnt = ack_len;
      else if (drv_cnt > 0)               drv_cnt--;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {int idx; logic [7:0] val; int stamp;} pend_t;
  typedef struct {bit is_clear; logic [1:0] row; logic [3:0] col; logic [7:0] ch;} obs_t;

  pend_t pend_q[$];
  obs_t  obs[$];
  int    cyc = 0;
  bit    m_clr_pend = 1'b0;
  int    m_clr_stamp = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        if (wr_en) pend_q.push_back('{int'(wr_row) * 16 + int'(wr_col), wr_char, cyc});
        if (clr_req) begin
          m_clr_pend  = 1'b1;
          m_clr_stamp = cyc;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  bit   mon_en       = 1'b0;
  bit   expect_quiet = 1'b0;
  logic ready_prev   = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && mon_en) begin
        chk(!(drv_showchar && drv_clear), "req_exclusive", {drv_showchar, drv_clear}, 0);
        if (drv_showchar || drv_clear)
          chk(ready_prev == 1'b1, "req_while_driver_busy", ready_prev, 1);
        if (drv_showchar) begin
          int idx;
          int hit;
          idx = int'(drv_char_row) * 16 + int'(drv_char_col);
          hit = -1;
          for (int i = 0; i < pend_q.size(); i++) begin
            if (pend_q[i].idx == idx && pend_q[i].val == drv_charval) begin
              hit = i;
              break;
            end
          end
          chk(hit >= 0, "showchar_matches_written_value", {idx[7:0], drv_charval}, 0);
          if (hit >= 0) begin
            for (int i = hit; i >= 0; i--)
              if (pend_q[i].idx == idx) pend_q.delete(i);
          end
          obs.push_back('{1'b0, drv_char_row, drv_char_col, drv_charval});
        end
        if (drv_clear) begin
          chk(m_clr_pend, "clear_was_requested", drv_clear, m_clr_pend);
          for (int i = pend_q.size() - 1; i >= 0; i--)
            if (pend_q[i].stamp < cyc) pend_q.delete(i);
          if (m_clr_stamp < cyc) m_clr_pend = 1'b0;
          obs.push_back('{1'b1, 2'd0, 4'd0, 8'd0});
        end
        if (pend_q.size() > 0 || m_clr_pend)
          chk(busy == 1'b1, "busy_while_work_pending", busy, 1);
        if (expect_quiet)
          chk(!busy && !drv_showchar && !drv_clear, "quiet_when_idle",
              {busy, drv_showchar, drv_clear}, 0);
      end
      ready_prev = drv_ready;
    end
  end

  // ---------------- stimulus helpers (called at posedge+2) ----------------
  task automatic do_reset();
    mon_en = 1'b0;
    rst    = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    pend_q.delete();
    obs.delete();
    m_clr_pend = 1'b0;
    hold       = 1'b0;
    rst        = 1'b0;
    mon_en     = 1'b1;
  endtask

  task automatic wr(input logic [1:0] r, input logic [3:0] c, input logic [7:0] ch);
    wr_en = 1'b1; wr_row = r; wr_col = c; wr_char = ch;
    @(posedge clk); #2;
    wr_en = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (obs.size() < n && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    chk(obs.size() >= n, name, obs.size(), n);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    chk(!busy, name, busy, 0);
  endtask

  task automatic chk_show(input int i, input logic [1:0] r, input logic [3:0] c,
                          input logic [7:0] ch, input string name);
    if (obs.size() > i)
      chk(!obs[i].is_clear && obs[i].row == r && obs[i].col == c && obs[i].ch == ch, name,
          {obs[i].is_clear, obs[i].row, obs[i].col, obs[i].ch}, {1'b0, r, c, ch});
    else
      chk(1'b0, name, obs.size(), i + 1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_char = '0; clr_req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk(busy == 1'b0,         "reset_busy",     busy, 0);
    chk(drv_showchar == 1'b0, "reset_showchar", drv_showchar, 0);
    chk(drv_clear == 1'b0,    "reset_clear",    drv_clear, 0);
    chk(drv_char_row == 2'd0, "reset_row",      drv_char_row, 0);
    chk(drv_char_col == 4'd0, "reset_col",      drv_char_col, 0);
    chk(drv_charval == 8'd0,  "reset_charval",  drv_charval, 0);
    chk(err == 1'b0,          "reset_err",      err, 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // 1: nothing written -> nothing sent, never busy
    expect_quiet = 1'b1;
    repeat (200) @(posedge clk);
    #2;
    expect_quiet = 1'b0;
    chk(obs.size() == 0, "idle_no_requests", obs.size(), 0);

    // 2: single cell
    do_reset();
    wr(2'd1, 4'd3, 8'h41);
    wait_obs(1, 200, "single_showchar_seen");
    repeat (5) @(posedge clk);
    #2;
    chk(busy == 1'b1, "busy_during_driver_ack", busy, 1);
    wait_idle(100, "single_busy_falls");
    repeat (70) @(posedge clk);
    #2;
    chk(obs.size() == 1, "single_exactly_one", obs.size(), 1);
    chk_show(0, 2'd1, 4'd3, 8'h41, "single_payload");

    // 3: rewrite while first draw is in flight
    do_reset();
    wr(2'd0, 4'd0, 8'h41);
    wait_obs(1, 200, "rewrite_first_seen");
    wr(2'd0, 4'd0, 8'h42);
    wait_obs(2, 200, "rewrite_second_seen");
    wait_idle(100, "rewrite_idle");
    repeat (70) @(posedge clk);
    #2;
    chk(obs.size() == 2, "rewrite_two_draws", obs.size(), 2);
    chk_show(0, 2'd0, 4'd0, 8'h41, "rewrite_first_value");
    chk_show(1, 2'd0, 4'd0, 8'h42, "rewrite_second_value");

    // 4: clear while cell 5 is in flight supersedes cell 60
    do_reset();
    wr(2'd0, 4'd5, 8'h35);
    wr(2'd3, 4'd12, 8'h3C);
    wait_obs(1, 100, "clr_first_seen");
    chk_show(0, 2'd0, 4'd5, 8'h35, "clr_cell5_drawn_first");
    clr_req = 1'b1;
    @(posedge clk); #2;
    clr_req = 1'b0;
    wait_obs(2, 200, "clr_clear_seen");
    wait_idle(100, "clr_idle");
    repeat (70) @(posedge clk);
    #2;
    chk(obs.size() == 2, "clr_no_cell60_draw", obs.size(), 2);
    if (obs.size() > 1) chk(obs[1].is_clear, "clr_second_is_clear", obs[1].is_clear, 1);

    // 5: write lands in the ISSUE cycle of the same cell
    do_reset();
    hold = 1'b1;
    wr(2'd0, 4'd7, 8'h11);
    repeat (30) @(posedge clk);
    #2;
    hold = 1'b0;
    wr(2'd0, 4'd7, 8'h5A);
    wait_obs(2, 300, "issue_race_two_seen");
    wait_idle(100, "issue_race_idle");
    repeat (70) @(posedge clk);
    #2;
    chk(obs.size() == 2, "issue_race_two_draws", obs.size(), 2);
    chk_show(0, 2'd0, 4'd7, 8'h11, "issue_race_old_value");
    chk_show(1, 2'd0, 4'd7, 8'h5A, "issue_race_new_value");

`ifdef OLED_SEQ_WATCHDOG_EN
    // 6: driver stalls after accepting -> timeout, err, reissue
    do_reset();
    wr(2'd2, 4'd2, 8'h77);
    wait_obs(1, 200, "wdog_first_seen");
    hold = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    chk(err == 1'b0, "wdog_err_not_early", err, 0);
    begin
      int k;
      k = 0;
      while (!err && k < 80) begin
        @(posedge clk); #2;
        k++;
      end
    end
    chk(err == 1'b1, "wdog_err_set", err, 1);
    pend_q.push_back('{34, 8'h77, cyc});
    hold = 1'b0;
    wait_obs(2, 200, "wdog_reissue_seen");
    wait_idle(100, "wdog_idle");
    chk_show(1, 2'd2, 4'd2, 8'h77, "wdog_reissue_payload");
    chk(err == 1'b1, "wdog_err_sticky", err, 1);
    do_reset();
    #1;
    chk(err == 1'b0, "wdog_err_cleared_by_reset", err, 0);
`endif

    chk(pend_q.size() == 0, "all_writes_drawn", pend_q.size(), 0);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

endmodule
